mc_ctrl: RTL and testbench

//  Multi-cycle sequencer for the MIPS-subset datapath (PC, IR, regfile, ALU, extender, data memory).

---
 rtl/mc_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the MIPS-subset datapath.
// Drives per-step enables and mux selects and counts retired instructions.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             MemW,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             RegW,
  output logic             RegDst,
  output logic             Mem2R,
  output logic             Alusrc,
  output logic             ExtOp,
  output logic [4:0]       Aluctrl,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [4:0] ALUOP_ADDU = 5'd1;
  localparam logic [4:0] ALUOP_SUBU = 5'd2;
  localparam logic [4:0] ALUOP_OR   = 5'd4;
  localparam logic [4:0] ALUOP_LUI  = 5'd8;
  localparam logic       EXT_ZERO   = 1'b0;
  localparam logic       EXT_SIGNED = 1'b1;

  state_t           cur_q;
  state_t           nxt;
  logic             retire;
  logic [CNT_W-1:0] cnt_q;

  logic is_addu, is_subu, is_rv, is_j, is_beq, is_ori, is_lui, is_lw, is_sw, legal;

  always_comb begin
    is_addu = (OpCode == OP_RTYPE) && (funct == FN_ADDU);
    is_subu = (OpCode == OP_RTYPE) && (funct == FN_SUBU);
    is_rv   = is_addu || is_subu;
    is_j    = (OpCode == OP_J);
    is_beq  = (OpCode == OP_BEQ);
    is_ori  = (OpCode == OP_ORI);
    is_lui  = (OpCode == OP_LUI);
    is_lw   = (OpCode == OP_LW);
    is_sw   = (OpCode == OP_SW);
    legal   = is_rv || is_j || is_beq || is_ori || is_lui || is_lw || is_sw;
  end

  // Next state and the "last cycle of an instruction" strobe
  always_comb begin
    nxt    = cur_q;
    retire = 1'b0;
    case (cur_q)
      S_IF: if (mem_ack) nxt = S_ID;
      S_ID: begin
        if (is_j || !legal) begin
          nxt    = S_IF;
          retire = 1'b1;
        end else begin
          nxt = S_EX;
        end
      end
      S_EX: begin
        if (is_lw || is_sw) begin
          nxt = S_MEM;
        end else if (is_beq) begin
          nxt    = S_IF;
          retire = 1'b1;
        end else if (is_rv || is_ori || is_lui) begin
          nxt = S_WB;
        end else begin
          nxt = S_IF;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          if (is_lw) begin
            nxt = S_WB;
          end else begin
            nxt    = S_IF;
            retire = 1'b1;
          end
        end
      end
      S_WB: begin
        nxt    = S_IF;
        retire = 1'b1;
      end
      default: nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= S_IF;
      cnt_q <= '0;
    end else begin
      cur_q <= nxt;
      if (retire) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Strobes follow the current step; IF strobes are masked while rst_n is low
  // so nothing is written during reset even if mem_ack is high.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    MemW     = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 2'd0;
    RegW     = 1'b0;
    RegDst   = 1'b0;
    Mem2R    = 1'b0;
    Alusrc   = 1'b0;
    ExtOp    = EXT_ZERO;
    Aluctrl  = 5'd0;
    illegal  = 1'b0;
    case (cur_q)
      S_IF: begin
        imem_req = 1'b1;
        ir_we    = mem_ack && rst_n;
        pc_we    = mem_ack && rst_n;
      end
      S_ID: begin
        if (is_j) begin
          pc_we  = 1'b1;
          pc_src = 2'd2;
        end
        illegal = !legal;
      end
      S_EX: begin
        if (is_rv) begin
          RegDst  = 1'b1;
          Aluctrl = is_addu ? ALUOP_ADDU : ALUOP_SUBU;
        end else if (is_lw || is_sw) begin
          Alusrc  = 1'b1;
          ExtOp   = EXT_SIGNED;
          Aluctrl = ALUOP_ADDU;
        end else if (is_ori) begin
          Alusrc  = 1'b1;
          ExtOp   = EXT_ZERO;
          Aluctrl = ALUOP_OR;
        end else if (is_lui) begin
          Alusrc  = 1'b1;
          Aluctrl = ALUOP_LUI;
        end else if (is_beq) begin
          Aluctrl = ALUOP_SUBU;
          ExtOp   = EXT_SIGNED;
          pc_we   = zero;
          pc_src  = zero ? 2'd1 : 2'd0;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        MemW     = is_sw;
      end
      S_WB: begin
        RegW   = 1'b1;
        RegDst = is_rv;
        Mem2R  = is_lw;
      end
      default: ;
    endcase
  end

  assign state   = cur_q;
  assign retired = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expected control vectors go through
// a scoreboard queue and are compared against the DUT away from the clock edge.
module tb_mc_ctrl;
  localparam int CNT_W = 4;

  localparam logic [4:0] A_ADDU = 5'd1;
  localparam logic [4:0] A_SUBU = 5'd2;
  localparam logic [4:0] A_OR   = 5'd4;
  localparam logic [4:0] A_LUI  = 5'd8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       OpCode, funct;
  logic             zero, mem_ack;
  logic             imem_req, dmem_req, MemW, ir_we, pc_we;
  logic [1:0]       pc_src;
  logic             RegW, RegDst, Mem2R, Alusrc, ExtOp;
  logic [4:0]       Aluctrl;
  logic [2:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .imem_req(imem_req), .dmem_req(dmem_req), .MemW(MemW),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .RegW(RegW), .RegDst(RegDst),
    .Mem2R(Mem2R), .Alusrc(Alusrc), .ExtOp(ExtOp), .Aluctrl(Aluctrl),
    .state(state), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req, dmem_req, memw, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       regw, regdst, mem2r, alusrc, extop;
    logic [4:0] aluctrl;
    logic       ill;
  } ctl_t;

  ctl_t  sb[$];
  string tq[$];
  int    total = 0;
  int    bad = 0;

  function automatic ctl_t obs();
    ctl_t o;
    o.st = state; o.imem_req = imem_req; o.dmem_req = dmem_req; o.memw = MemW;
    o.ir_we = ir_we; o.pc_we = pc_we; o.pc_src = pc_src; o.regw = RegW;
    o.regdst = RegDst; o.mem2r = Mem2R; o.alusrc = Alusrc; o.extop = ExtOp;
    o.aluctrl = Aluctrl; o.ill = illegal;
    return o;
  endfunction

  function automatic ctl_t z(input logic [2:0] s);
    ctl_t c = '0;
    c.st = s;
    return c;
  endfunction

  function automatic ctl_t c_if(input logic ack);
    ctl_t c = z(3'd0);
    c.imem_req = 1'b1; c.ir_we = ack; c.pc_we = ack;
    return c;
  endfunction

  function automatic ctl_t c_id_j();
    ctl_t c = z(3'd1);
    c.pc_we = 1'b1; c.pc_src = 2'd2;
    return c;
  endfunction

  function automatic ctl_t c_id_ill();
    ctl_t c = z(3'd1);
    c.ill = 1'b1;
    return c;
  endfunction

  function automatic ctl_t c_ex_r(input logic [4:0] alu);
    ctl_t c = z(3'd2);
    c.regdst = 1'b1; c.aluctrl = alu;
    return c;
  endfunction

  function automatic ctl_t c_ex_ls();
    ctl_t c = z(3'd2);
    c.alusrc = 1'b1; c.extop = 1'b1; c.aluctrl = A_ADDU;
    return c;
  endfunction

  function automatic ctl_t c_ex_imm(input logic [4:0] alu);
    ctl_t c = z(3'd2);
    c.alusrc = 1'b1; c.extop = 1'b0; c.aluctrl = alu;
    return c;
  endfunction

  function automatic ctl_t c_ex_beq(input logic zf);
    ctl_t c = z(3'd2);
    c.aluctrl = A_SUBU; c.extop = 1'b1; c.pc_we = zf; c.pc_src = zf ? 2'd1 : 2'd0;
    return c;
  endfunction

  function automatic ctl_t c_mem(input logic w);
    ctl_t c = z(3'd3);
    c.dmem_req = 1'b1; c.memw = w;
    return c;
  endfunction

  function automatic ctl_t c_wb(input logic dst, input logic m2r);
    ctl_t c = z(3'd4);
    c.regw = 1'b1; c.regdst = dst; c.mem2r = m2r;
    return c;
  endfunction

  task automatic check_pop();
    ctl_t  got, want;
    string t;
    want = sb.pop_front();
    t    = tq.pop_front();
    got  = obs();
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", t, got, want);
    end
  endtask

  task automatic step(input string tag, input ctl_t e);
    sb.push_back(e);
    tq.push_back(tag);
    @(negedge clk);
    check_pop();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ret(input string tag, input logic [CNT_W-1:0] v);
    total++;
    assert (retired === v) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, retired, v);
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n   = 1'b0;
    mem_ack = 1'b1;
    #1;
    sb.push_back(c_if(1'b0));
    tq.push_back(tag);
    check_pop();
    chk_ret({tag, "_ret"}, '0);
    mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; OpCode = '0; funct = '0; zero = 1'b0; mem_ack = 1'b0;
    #2;

    // addu with zero-wait memory and mem_ack high throughout
    do_reset("t1_rst");
    OpCode = 6'b000000; funct = 6'b100001; mem_ack = 1'b1;
    step("t1_if", c_if(1'b1));
    step("t1_id", z(3'd1));
    step("t1_ex", c_ex_r(A_ADDU));
    step("t1_wb", c_wb(1'b1, 1'b0));
    chk_ret("t1_ret", 4'd1);

    // lw with three wait cycles in MEM
    do_reset("t2_rst");
    OpCode = 6'b100011; mem_ack = 1'b1;
    step("t2_if", c_if(1'b1));
    mem_ack = 1'b0;
    step("t2_id", z(3'd1));
    step("t2_ex", c_ex_ls());
    for (int i = 0; i < 3; i++) step("t2_mem_wait", c_mem(1'b0));
    mem_ack = 1'b1;
    step("t2_mem_ack", c_mem(1'b0));
    mem_ack = 1'b0;
    step("t2_wb", c_wb(1'b0, 1'b1));
    step("t2_back_if", c_if(1'b0));
    chk_ret("t2_ret", 4'd1);

    // sw, beq taken, beq not taken
    do_reset("t3_rst");
    OpCode = 6'b101011; mem_ack = 1'b0;
    step("t3_if_wait", c_if(1'b0));
    mem_ack = 1'b1;
    step("t3_sw_if", c_if(1'b1));
    step("t3_sw_id", z(3'd1));
    step("t3_sw_ex", c_ex_ls());
    step("t3_sw_mem", c_mem(1'b1));
    OpCode = 6'b000100; zero = 1'b1;
    step("t3_beq1_if", c_if(1'b1));
    step("t3_beq1_id", z(3'd1));
    step("t3_beq1_ex", c_ex_beq(1'b1));
    zero = 1'b0;
    step("t3_beq0_if", c_if(1'b1));
    step("t3_beq0_id", z(3'd1));
    step("t3_beq0_ex", c_ex_beq(1'b0));
    chk_ret("t3_ret", 4'd3);

    // j, then ori and lui
    OpCode = 6'b000010;
    step("t4_j_if", c_if(1'b1));
    step("t4_j_id", c_id_j());
    chk_ret("t4_ret_j", 4'd4);
    OpCode = 6'b001101;
    step("t4_ori_if", c_if(1'b1));
    step("t4_ori_id", z(3'd1));
    step("t4_ori_ex", c_ex_imm(A_OR));
    step("t4_ori_wb", c_wb(1'b0, 1'b0));
    OpCode = 6'b001111;
    step("t4_lui_if", c_if(1'b1));
    step("t4_lui_id", z(3'd1));
    step("t4_lui_ex", c_ex_imm(A_LUI));
    step("t4_lui_wb", c_wb(1'b0, 1'b0));
    mem_ack = 1'b0;
    step("t4_back_if", c_if(1'b0));
    chk_ret("t4_ret", 4'd6);

    // undefined opcode, then R-type with undefined funct
    do_reset("t5_rst");
    mem_ack = 1'b1; OpCode = 6'b111111;
    step("t5_op_if", c_if(1'b1));
    step("t5_op_id", c_id_ill());
    OpCode = 6'b000000; funct = 6'b000000;
    step("t5_fn_if", c_if(1'b1));
    step("t5_fn_id", c_id_ill());
    mem_ack = 1'b0;
    step("t5_back_if", c_if(1'b0));
    chk_ret("t5_ret", 4'd2);

    // reset while sw waits in MEM
    OpCode = 6'b101011; mem_ack = 1'b1;
    step("t6_if", c_if(1'b1));
    mem_ack = 1'b0;
    step("t6_id", z(3'd1));
    step("t6_ex", c_ex_ls());
    step("t6_mem", c_mem(1'b1));
    do_reset("t6_rst");
    step("t6_after_rst", c_if(1'b0));
    chk_ret("t6_ret_after", 4'd0);

    // counter wraps from all-ones to zero
    OpCode = 6'b000010; mem_ack = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step("wrap_if", c_if(1'b1));
      step("wrap_id", c_id_j());
    end
    chk_ret("wrap_max", 4'd15);
    step("wrap_last_if", c_if(1'b1));
    step("wrap_last_id", c_id_j());
    chk_ret("wrap_zero", 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
